// File: rtl/ws_act_skew_feeder.sv
// Diagonal-skew activation feeder for the weight-stationary PE array.
// Optional WS_FEEDER_STALL_CNT_EN adds the stall_cnt output.
module ws_act_skew_feeder #(
  parameter int DATA_W = 8,
  parameter int N      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N*DATA_W-1:0] s_data,
  input  logic                s_last,
  output logic [N*DATA_W-1:0] arr_act,
  output logic [N-1:0]        arr_clear_acc,
  output logic                arr_en,
  output logic                tile_done
`ifdef WS_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((N > 1) ? (N - 2) : 0);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           accept;
  logic           first;
  logic           advance;
  logic           fin;
  logic           en_q;
  logic           done_q;

  assign s_ready = (state_q != DRAIN);
  assign accept  = s_valid & s_ready;
  assign first   = accept & (state_q == IDLE);
  assign advance = accept | (state_q == DRAIN);

  // Next state, drain count and end-of-tile detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    unique case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (s_last) begin
            if (N > 1) begin
              state_d = DRAIN;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
              fin     = 1'b1;
            end
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          fin     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered array strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= advance;
      done_q  <= fin;
    end
  end

  assign arr_en    = en_q;
  assign tile_done = done_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [i:0][DATA_W-1:0] d_q;
    logic [i:0]             f_q;
    logic [DATA_W-1:0]      din;

    assign din = accept ? s_data[i*DATA_W +: DATA_W] : '0;

    if (i == 0) begin : g_one
      // Lane 0: single output register, moves on advance only.
      always_ff @(posedge clk) begin
        if (rst) begin
          d_q <= '0;
          f_q <= '0;
        end else if (advance) begin
          d_q <= din;
          f_q <= first;
        end
      end
    end else begin : g_chain
      // Lane i: i+1 deep shift chain, moves on advance only.
      always_ff @(posedge clk) begin
        if (rst) begin
          d_q <= '0;
          f_q <= '0;
        end else if (advance) begin
          d_q <= {d_q[i-1:0], din};
          f_q <= {f_q[i-1:0], first};
        end
      end
    end

    assign arr_act[i*DATA_W +: DATA_W] = d_q[i];
    assign arr_clear_acc[i]            = f_q[i];
  end

`ifdef WS_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count starved STREAM cycles; restart at each tile start.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == IDLE && state_d != IDLE) begin
      stall_q <= '0;
    end else if (state_q == STREAM && !s_valid) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
